// File: rtl/mult_arbiter_pkg.sv
// Shared constants and elaboration helpers for the multiplier arbiter slice.
// Latency and id width are derived here so every module agrees on them.
package mult_arbiter_pkg;

   localparam int DEFAULT_WIDTH = 6;
   localparam int DEFAULT_N_REQ = 4;

   // The shift-add multiplier retires one operand bit per pipeline stage.
   function automatic int mult_latency(input int width);
      return width;
   endfunction

   // Width of an encoded requester id; at least one bit even for a single requester.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts just after the pointer
// and wraps; the pointer register itself lives in the caller.
module rr_arbiter
   import mult_arbiter_pkg::*;
#(
   parameter int N_REQ = DEFAULT_N_REQ,
   parameter int ID_W  = id_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  pointer,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  id,
   output logic             any
);

   always_comb begin
      int idx;
      grant = '0;
      id    = '0;
      any   = 1'b0;
      idx   = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = (int'(pointer) + k) % N_REQ;
         if (!any && req[idx]) begin
            any        = 1'b1;
            grant[idx] = 1'b1;
            id         = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/slow_multiplication.sv
// Fully pipelined unsigned shift-add multiplier, one operand bit per stage.
// No reset: stage contents are meaningless until valid data has flushed through.
module slow_multiplication #(
   parameter int WIDTH = 6
) (
   input  logic                 clk,
   input  logic                 enable,
   input  logic [WIDTH-1:0]     in_1,
   input  logic [WIDTH-1:0]     in_2,
   output logic [2*WIDTH-1:0]   out
);

   // Each stage holds {partial sum, remaining multiplier bits} in one word,
   // so the multiplicand is the only extra state carried down the pipe.
   logic [2*WIDTH-1:0] p_reg [0:WIDTH-1];
   logic [WIDTH-1:0]   a_reg [0:WIDTH-2];

   function automatic logic [2*WIDTH-1:0] mul_step(
      input logic [2*WIDTH-1:0] p,
      input logic [WIDTH-1:0]   a
   );
      logic [WIDTH:0] sum;
      sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, a} : '0);
      return {sum, p[WIDTH-1:1]};
   endfunction

   always_ff @(posedge clk) begin
      if (enable) begin
         p_reg[0] <= mul_step({{WIDTH{1'b0}}, in_2}, in_1);
         a_reg[0] <= in_1;
         for (int k = 1; k < WIDTH; k++) begin
            p_reg[k] <= mul_step(p_reg[k-1], a_reg[k-1]);
         end
         for (int k = 1; k < WIDTH - 1; k++) begin
            a_reg[k] <= a_reg[k-1];
         end
      end
   end

   assign out = p_reg[WIDTH-1];

endmodule

// File: rtl/mult_arbiter.sv
// Shares one pipelined multiplier between N_REQ requesters with round-robin
// arbitration; a tag pipeline steers each product back to its issuer.
module mult_arbiter
   import mult_arbiter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int N_REQ = DEFAULT_N_REQ
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*WIDTH-1:0]   in_1_flat,
   input  logic [N_REQ*WIDTH-1:0]   in_2_flat,
   output logic [N_REQ-1:0]         ack,
   output logic [N_REQ-1:0]         res_valid,
   output logic [2*WIDTH-1:0]       res_data,
   output logic                     busy
);

   localparam int LATENCY = mult_latency(WIDTH);
   localparam int ID_W    = id_width(N_REQ);

   logic [ID_W-1:0]    pointer_reg;
   logic [N_REQ-1:0]   grant;
   logic [ID_W-1:0]    win_id;
   logic               grant_any;
   logic               issue;

   logic [WIDTH-1:0]   op_1_q;
   logic [WIDTH-1:0]   op_2_q;
   logic [2*WIDTH-1:0] mult_out;

   // One extra stage covers the operand register in front of the multiplier.
   logic [LATENCY:0]   tag_valid_reg;
   logic [ID_W-1:0]    tag_id_reg [0:LATENCY];

   rr_arbiter #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_arb (
      .req     (req),
      .pointer (pointer_reg),
      .grant   (grant),
      .id      (win_id),
      .any     (grant_any)
   );

   // Nothing is granted while reset is held, so ack reads zero then too.
   assign issue = grant_any & reset;
   assign ack   = reset ? grant : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pointer_reg   <= ID_W'(N_REQ - 1);
         op_1_q        <= '0;
         op_2_q        <= '0;
         tag_valid_reg <= '0;
         for (int k = 0; k <= LATENCY; k++) begin
            tag_id_reg[k] <= '0;
         end
      end else begin
         if (issue) begin
            pointer_reg <= win_id;
            op_1_q      <= in_1_flat[int'(win_id)*WIDTH +: WIDTH];
            op_2_q      <= in_2_flat[int'(win_id)*WIDTH +: WIDTH];
         end
         tag_valid_reg[0] <= issue;
         tag_id_reg[0]    <= win_id;
         for (int k = 1; k <= LATENCY; k++) begin
            tag_valid_reg[k] <= tag_valid_reg[k-1];
            tag_id_reg[k]    <= tag_id_reg[k-1];
         end
      end
   end

   slow_multiplication #(
      .WIDTH (WIDTH)
   ) u_mult (
      .clk    (clk),
      .enable (1'b1),
      .in_1   (op_1_q),
      .in_2   (op_2_q),
      .out    (mult_out)
   );

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_res_valid
      assign res_valid[gi] = tag_valid_reg[LATENCY] && (tag_id_reg[LATENCY] == ID_W'(gi));
   end

   assign res_data = mult_out;
   assign busy     = |tag_valid_reg;

endmodule
